// File: rtl/go_sched_pkg.sv
// ---------------------------------------------------------------------------
// go_sched_pkg
// Shared definitions for the round-robin go-delay scheduler.
//   state_t     : FSM encoding (IDLE, RUN, DONE)
//   NREQ_MIN/MAX: supported range of requester counts
//   nreq_legal(): elaboration-time check of the NREQ parameter
// ---------------------------------------------------------------------------
package go_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NREQ_MIN = 2;
   localparam int NREQ_MAX = 8;

   function automatic bit nreq_legal(input int n);
      return (n >= NREQ_MIN) && (n <= NREQ_MAX);
   endfunction

endpackage

// File: rtl/go_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans the eligible vector starting at
// ptr and wrapping modulo NREQ; reports the first set index.
//   elig  : eligible requesters (req & ~kill)
//   ptr   : index with highest priority this round
//   valid : at least one requester is eligible
//   pick  : index of the chosen requester (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_pick
   import go_sched_pkg::*;
#(
   parameter  int NREQ  = 3,
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  elig,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] pick
);

   // idx_at[i] is the requester index visited at scan offset i.
   logic [IDX_W-1:0] idx_at [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign idx_at[gi] = (sum >= (IDX_W+1)'(NREQ)) ?
                          IDX_W'(sum - (IDX_W+1)'(NREQ)) : sum[IDX_W-1:0];
   end

   // Scan from the farthest offset down so the nearest eligible index wins.
   always_comb begin
      valid = 1'b0;
      pick  = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (elig[idx_at[i]]) begin
            valid = 1'b1;
            pick  = idx_at[i];
         end
      end
   end

endmodule

// File: rtl/go_sched_rr.sv
// ---------------------------------------------------------------------------
// go_sched_rr
// Round-robin scheduler sharing one programmable delay engine among NREQ
// requesters. A granted requester holds grant for dly_cfg+1 cycles, then
// receives a one-cycle done pulse. kill on the granted index aborts the
// service and sets the sticky kill_ltchd flag.
//   clk, reset : clock, asynchronous active-high reset
//   req        : level request per requester
//   kill       : abort / mask per requester
//   dly_cfg    : delay value, sampled at grant
//   kill_clr   : synchronous clear of kill_ltchd (wins over a new abort)
//   grant      : one-hot grant, high for the whole service window
//   done       : one-cycle pulse on a completed service
//   busy       : state is not IDLE
//   kill_ltchd : sticky abort flag
// ---------------------------------------------------------------------------
module go_sched_rr
   import go_sched_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int DLY_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  kill,
   input  logic [DLY_W-1:0] dly_cfg,
   input  logic             kill_clr,
   output logic [NREQ-1:0]  grant,
   output logic [NREQ-1:0]  done,
   output logic             busy,
   output logic             kill_ltchd
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (!nreq_legal(NREQ)) begin : g_bad_nreq
      $error("go_sched_rr: NREQ=%0d outside legal range", NREQ);
   end

   state_t           state_reg;
   logic [IDX_W-1:0] ptr_reg;
   logic [DLY_W-1:0] cnt_reg;
   logic [NREQ-1:0]  grant_reg;
   logic [NREQ-1:0]  done_reg;
   logic             busy_reg;
   logic             kill_ltchd_reg;

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [NREQ-1:0]  pick_onehot;
   logic [IDX_W-1:0] ptr_next;
   logic             abort;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .elig  (req & ~kill),
      .ptr   (ptr_reg),
      .valid (pick_valid),
      .pick  (pick_idx)
   );

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == IDX_W'(gi));
   end

   assign ptr_next = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

   // Only kill on the currently granted index aborts; grant_reg is zero
   // outside RUN, so the state qualifier just documents intent.
   assign abort = (state_reg == RUN) && |(kill & grant_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         ptr_reg        <= '0;
         cnt_reg        <= '0;
         grant_reg      <= '0;
         done_reg       <= '0;
         busy_reg       <= 1'b0;
         kill_ltchd_reg <= 1'b0;
      end else begin
         done_reg <= '0;

         case (state_reg)
            IDLE: begin
               if (pick_valid) begin
                  state_reg <= RUN;
                  grant_reg <= pick_onehot;
                  cnt_reg   <= dly_cfg;
                  ptr_reg   <= ptr_next;
                  busy_reg  <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  state_reg <= IDLE;
                  grant_reg <= '0;
                  busy_reg  <= 1'b0;
               end else if (cnt_reg == '0) begin
                  state_reg <= DONE;
                  grant_reg <= '0;
                  done_reg  <= grant_reg;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               grant_reg <= '0;
               busy_reg  <= 1'b0;
            end
         endcase

         if (kill_clr) begin
            kill_ltchd_reg <= 1'b0;
         end else if (abort) begin
            kill_ltchd_reg <= 1'b1;
         end
      end
   end

   assign grant      = grant_reg;
   assign done       = done_reg;
   assign busy       = busy_reg;
   assign kill_ltchd = kill_ltchd_reg;

endmodule
